// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl: PLL reset sequencer and lock supervisor on the 24 MHz refclk.
// Holds the PLL in reset, waits for a stable synchronised lock, then releases
// the system reset request; any lock loss in RUN restarts the whole sequence.
// Optional feature macro: PLL_LOCK_CTRL_TIMEOUT_EN enables the WAIT_LOCK
// timeout/retry path and the retry counter (default build: wait forever).
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   RESET      | pll_reset high for RST_CYCLES refclk cycles
//   WAIT_LOCK  | PLL running, waiting for lock_s (optionally with timeout)
//   STABLE     | lock_s seen, requiring STABLE_CYCLES consecutive locked cycles
//   RUN        | system reset released; lock loss returns to RESET
module pll_lock_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 24000,
  parameter int STABLE_CYCLES = 1024,
  parameter int CNT_W         = 8
) (
  input  logic             refclk,
  input  logic             reset_n,
  input  logic             extlock,
  input  logic             restart,
  output logic             pll_reset,
  output logic             sys_rst_n,
  output logic             locked_ok,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] retry_cnt,
  output logic [CNT_W-1:0] loss_cnt
);

  // Shared cycle counter is sized to cover the longest of the three timers.
  localparam int MAX_A = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
  localparam int MAX_C = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
  localparam int CW    = $clog2(MAX_C + 1);

  typedef enum logic [1:0] {
    S_RESET     = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_e;

  logic             sync1_q;
  logic             lock_s_q;
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] loss_q, loss_d;
  logic             pll_reset_q, sys_rst_n_q, locked_ok_q;
`ifdef PLL_LOCK_CTRL_TIMEOUT_EN
  logic [CNT_W-1:0] retry_q, retry_d;
`endif

  // Two-flop synchroniser for the asynchronous PLL lock indication.
  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= extlock;
      lock_s_q <= sync1_q;
    end
  end

  // Next-state, shared-counter and event-counter logic; restart overrides all.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    loss_d  = loss_q;
`ifdef PLL_LOCK_CTRL_TIMEOUT_EN
    retry_d = retry_q;
`endif
    if (restart) begin
      state_d = S_RESET;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_RESET: begin
          if (cnt_q == CW'(RST_CYCLES - 1)) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end
        end
        S_WAIT_LOCK: begin
          // Lock arrival beats a simultaneous timeout.
          if (lock_s_q) begin
            state_d = S_STABLE;
            cnt_d   = '0;
          end
`ifdef PLL_LOCK_CTRL_TIMEOUT_EN
          else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
            state_d = S_RESET;
            cnt_d   = '0;
            if (retry_q != '1) retry_d = retry_q + CNT_W'(1);
          end
`endif
        end
        S_STABLE: begin
          // A lock drop beats a simultaneous stable-window completion.
          if (!lock_s_q) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end
        end
        S_RUN: begin
          if (!lock_s_q) begin
            state_d = S_RESET;
            cnt_d   = '0;
            if (loss_q != '1) loss_d = loss_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = S_RESET;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counters and registered output decodes of the next state.
  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_RESET;
      cnt_q       <= '0;
      loss_q      <= '0;
      pll_reset_q <= 1'b1;
      sys_rst_n_q <= 1'b0;
      locked_ok_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      loss_q      <= loss_d;
      pll_reset_q <= (state_d == S_RESET);
      sys_rst_n_q <= (state_d == S_RUN);
      locked_ok_q <= (state_d == S_RUN);
    end
  end

`ifdef PLL_LOCK_CTRL_TIMEOUT_EN
  // Saturating count of WAIT_LOCK timeouts.
  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) retry_q <= '0;
    else          retry_q <= retry_d;
  end
  assign retry_cnt = retry_q;
`else
  assign retry_cnt = '0;
`endif

  assign pll_reset = pll_reset_q;
  assign sys_rst_n = sys_rst_n_q;
  assign locked_ok = locked_ok_q;
  assign state     = state_q;
  assign loss_cnt  = loss_q;

endmodule
